id_operand_stage: RTL and testbench
===================================

Name: id_operand_stage

Overview:
- Sits in ID directly downstream of the ID forwarding unit. Consumes its 3-bit per-operand forward selects.
- Builds the final rs/rt operands from the register file or from the EXE/MEM/MEM2/WB results.
- Stalls ID while a selected producer result is not yet valid.
- Captures forwarded operands across stalls, so the value survives after the producer leaves the pipe.
- Drives the ID/EXE pipeline register with valid/stall/flush handling.

Parameters:
- DATA_W, 32, operand/result width
- REG_W, 5, register index width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- ID_Valid  in  1  ID holds a live instruction
- ID_UsesRs  in  1  instruction reads rs
- ID_UsesRt  in  1  instruction reads rt
- ID_ForwardA  in  3  rs source select: 000 RF, 001 EXE, 010 MEM, 011 MEM2, 100 WB
- ID_ForwardB  in  3  rt source select, same encoding
- RF_RsData  in  DATA_W  register file rs read
- RF_RtData  in  DATA_W  register file rt read
- EXE_Result, MEM_Result, MEM2_Result, WB_Result  in  DATA_W each  stage results
- EXE_ResultValid, MEM_ResultValid, MEM2_ResultValid  in  1 each  result final this cycle (low for loads not yet returned, HI/LO pending)
- ID_Flush  in  1  kill ID instruction (branch/exception)
- EXE_Stall  in  1  EXE cannot accept
- ID_RsData  out  DATA_W  resolved rs, combinational (branch compare in ID)
- ID_RtData  out  DATA_W  resolved rt, combinational
- ID_Stall  out  1  hold PC and IF/ID
- EXE_Valid  out  1  registered: EXE holds a live instruction
- EXE_RsData  out  DATA_W  registered rs
- EXE_RtData  out  DATA_W  registered rt

Behaviour:
- Reset (rst=1 at posedge): EXE_Valid=0, EXE_RsData=0, EXE_RtData=0, both hold registers EMPTY.
- Per-operand source value (X = A/B):
  - If the hold reg is HELD: use the held value; ID_ForwardX is ignored.
  - Else mux on ID_ForwardX. WB is always valid; RF is always valid.
  - Codes 101-111 are illegal: treat as 000. Simulation assertion fires.
- Operand ok = !Uses || HELD || source valid.
- Ready = ID_Valid && okA && okB.
- Advance = Ready && !EXE_Stall && !ID_Flush.
- ID_Stall = ID_Valid && !ID_Flush && !Advance. Combinational, zero latency.
- Hold register per operand, 2 states:
  - EMPTY -> HELD when ID_Valid && !Advance && !ID_Flush && source valid. Captures the source value.
  - HELD -> EMPTY on Advance, ID_Flush, or rst.
  - HELD stays HELD otherwise; the value is frozen.
  - Capture happens regardless of the Uses bits.
- ID/EXE register, priority order:
  - rst: clear all.
  - else if EXE_Stall: hold all, including during ID_Flush. The flush kills only ID.
  - else if Advance: EXE_Valid=1, data = resolved operands.
  - else: EXE_Valid=0 (bubble). Data unchanged.
- Latency: operands appear in EXE one cycle after the Advance edge.
- Simultaneous events:
  - Flush and capture conditions in the same cycle: flush wins, no capture.
  - Producer becomes valid in the same cycle EXE_Stall deasserts: Advance fires that cycle and uses the live source.

Decomposition:
- Shared package (CPU defines): forward-select encoding constants FWD_RF/FWD_EXE/FWD_MEM/FWD_MEM2/FWD_WB, and the hold-state enum.
- One sub-module, operand_hold_slot: mux, hold register, ok signal. Instantiated twice.

Test Plan:
- Ready, no hazard:
  - Stimulus: ID_Valid=1, ForwardA=000, RF_RsData=0x11, ForwardB=100, WB_Result=0x22, no stalls.
  - Required: ID_Stall=0. Next cycle EXE_Valid=1, EXE_RsData=0x11, EXE_RtData=0x22.
- Load-use:
  - Stimulus: ForwardA=001, EXE_ResultValid=0 for 2 cycles.
  - Required: ID_Stall=1 and EXE_Valid=0 bubbles for 2 cycles.
  - Then MEM_ResultValid=1 with ForwardA=010, MEM_Result=0xDEAD. Required: advance, EXE_RsData=0xDEAD.
- Capture across stall:
  - Stimulus: ForwardB=100, WB_Result=0x55, EXE_Stall=1 for 3 cycles. From cycle 2, ForwardB=000 and RF_RtData=0x99 (stale).
  - Required: EXE_RtData=0x55 after release.
- Flush mid-stall:
  - Stimulus: HELD operand, ID_Flush=1, EXE_Stall=0.
  - Required: next cycle EXE_Valid=0 and holds EMPTY. A new instruction uses the live mux.
- Flush during EXE_Stall:
  - Stimulus: EXE_Valid=1 with data 0x77, ID_Flush=1 and EXE_Stall=1.
  - Required: EXE registers unchanged, holds cleared.
- Reset mid-stall:
  - Stimulus: rst=1 with HELD operands and EXE_Valid=1.
  - Required: all outputs zero. Holds EMPTY. ID_Stall follows inputs.

Source files
------------

// File: rtl/id_operand_stage_pkg.sv
// Shared CPU defines for the ID operand stage: forward-select encoding and the
// per-operand hold-register state.
package id_operand_stage_pkg;

    localparam logic [2:0] FWD_RF   = 3'b000;
    localparam logic [2:0] FWD_EXE  = 3'b001;
    localparam logic [2:0] FWD_MEM  = 3'b010;
    localparam logic [2:0] FWD_MEM2 = 3'b011;
    localparam logic [2:0] FWD_WB   = 3'b100;

    localparam int NUM_OPS = 2;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_HELD  = 1'b1
    } hold_state_t;

    function automatic logic fwd_legal(input logic [2:0] sel);
        return sel <= FWD_WB;
    endfunction

endpackage

// File: rtl/id_operand_stage_hold_slot.sv
// One operand lane: forward mux, capture register that freezes a forwarded value
// across stalls, and the per-operand ready term.
module operand_hold_slot
    import id_operand_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        fwd,
    input  logic              uses,
    input  logic [DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0] exe_result,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] mem2_result,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              exe_valid,
    input  logic              mem_valid,
    input  logic              mem2_valid,
    input  logic              capture,
    input  logic              clear,
    output logic [DATA_W-1:0] data,
    output logic              ok
);

    hold_state_t       state, state_nxt;
    logic [DATA_W-1:0] src;
    logic              src_valid;
    logic [DATA_W-1:0] held_val;
    logic              held;

    // Illegal selects fall back to the register file.
    always_comb begin
        src       = rf_data;
        src_valid = 1'b1;
        case (fwd)
            FWD_EXE:  begin src = exe_result;  src_valid = exe_valid;  end
            FWD_MEM:  begin src = mem_result;  src_valid = mem_valid;  end
            FWD_MEM2: begin src = mem2_result; src_valid = mem2_valid; end
            FWD_WB:   begin src = wb_result;   src_valid = 1'b1;       end
            default:  begin src = rf_data;     src_valid = 1'b1;       end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= HOLD_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HOLD_EMPTY: if (capture && src_valid) state_nxt = HOLD_HELD;
            HOLD_HELD:  if (clear)                state_nxt = HOLD_EMPTY;
            default:                              state_nxt = HOLD_EMPTY;
        endcase
    end

    always_comb begin
        held = (state == HOLD_HELD);
        data = held ? held_val : src;
        ok   = !uses || held || src_valid;
    end

    // Value only loads on the EMPTY->HELD transition, so it stays frozen while HELD.
    always_ff @(posedge clk) begin
        if (rst)
            held_val <= '0;
        else if (state == HOLD_EMPTY && capture && src_valid)
            held_val <= src;
    end

endmodule

// File: rtl/id_operand_stage.sv
// ID operand resolution: per-operand forward/hold slots, ID stall generation and
// the ID/EXE pipeline register.
module id_operand_stage
    import id_operand_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ID_Valid,
    input  logic              ID_UsesRs,
    input  logic              ID_UsesRt,
    input  logic [2:0]        ID_ForwardA,
    input  logic [2:0]        ID_ForwardB,
    input  logic [DATA_W-1:0] RF_RsData,
    input  logic [DATA_W-1:0] RF_RtData,
    input  logic [DATA_W-1:0] EXE_Result,
    input  logic [DATA_W-1:0] MEM_Result,
    input  logic [DATA_W-1:0] MEM2_Result,
    input  logic [DATA_W-1:0] WB_Result,
    input  logic              EXE_ResultValid,
    input  logic              MEM_ResultValid,
    input  logic              MEM2_ResultValid,
    input  logic              ID_Flush,
    input  logic              EXE_Stall,
    output logic [DATA_W-1:0] ID_RsData,
    output logic [DATA_W-1:0] ID_RtData,
    output logic              ID_Stall,
    output logic              EXE_Valid,
    output logic [DATA_W-1:0] EXE_RsData,
    output logic [DATA_W-1:0] EXE_RtData
);

    if (DATA_W < 1 || REG_W < 1) begin : g_bad_param
        $error("id_operand_stage: DATA_W and REG_W must be positive");
    end

    // Lane 0 is rs (ForwardA), lane 1 is rt (ForwardB).
    logic [NUM_OPS-1:0][2:0]        fwd;
    logic [NUM_OPS-1:0]             uses;
    logic [NUM_OPS-1:0][DATA_W-1:0] rf;
    logic [NUM_OPS-1:0][DATA_W-1:0] opnd;
    logic [NUM_OPS-1:0]             ok;
    logic                           ready, advance, capture, clear;

    assign fwd  = {ID_ForwardB, ID_ForwardA};
    assign uses = {ID_UsesRt, ID_UsesRs};
    assign rf   = {RF_RtData, RF_RsData};

    assign ready    = ID_Valid && (&ok);
    assign advance  = ready && !EXE_Stall && !ID_Flush;
    assign ID_Stall = ID_Valid && !ID_Flush && !advance;
    assign capture  = ID_Valid && !advance && !ID_Flush;
    assign clear    = advance || ID_Flush;

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_slot
        operand_hold_slot #(.DATA_W(DATA_W)) u_slot (
            .clk         (clk),
            .rst         (rst),
            .fwd         (fwd[i]),
            .uses        (uses[i]),
            .rf_data     (rf[i]),
            .exe_result  (EXE_Result),
            .mem_result  (MEM_Result),
            .mem2_result (MEM2_Result),
            .wb_result   (WB_Result),
            .exe_valid   (EXE_ResultValid),
            .mem_valid   (MEM_ResultValid),
            .mem2_valid  (MEM2_ResultValid),
            .capture     (capture),
            .clear       (clear),
            .data        (opnd[i]),
            .ok          (ok[i])
        );
    end

    assign ID_RsData = opnd[0];
    assign ID_RtData = opnd[1];

    // EXE_Stall freezes the register even across an ID flush; the flush only kills ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            EXE_Valid  <= 1'b0;
            EXE_RsData <= '0;
            EXE_RtData <= '0;
        end else if (!EXE_Stall) begin
            EXE_Valid <= advance;
            if (advance) begin
                EXE_RsData <= opnd[0];
                EXE_RtData <= opnd[1];
            end
        end
    end

    a_fwd_legal: assert property (@(posedge clk) disable iff (rst)
        ID_Valid |-> (fwd_legal(ID_ForwardA) && fwd_legal(ID_ForwardB)))
        else $error("id_operand_stage: illegal forward select A=%b B=%b",
                    ID_ForwardA, ID_ForwardB);

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: hazards, capture across stalls, flush and reset.
module tb_id_operand_stage;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              ID_Valid, ID_UsesRs, ID_UsesRt;
    logic [2:0]        ID_ForwardA, ID_ForwardB;
    logic [DATA_W-1:0] RF_RsData, RF_RtData;
    logic [DATA_W-1:0] EXE_Result, MEM_Result, MEM2_Result, WB_Result;
    logic              EXE_ResultValid, MEM_ResultValid, MEM2_ResultValid;
    logic              ID_Flush, EXE_Stall;
    logic [DATA_W-1:0] ID_RsData, ID_RtData;
    logic              ID_Stall, EXE_Valid;
    logic [DATA_W-1:0] EXE_RsData, EXE_RtData;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_operand_stage #(.DATA_W(DATA_W), .REG_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .ID_Valid         (ID_Valid),
        .ID_UsesRs        (ID_UsesRs),
        .ID_UsesRt        (ID_UsesRt),
        .ID_ForwardA      (ID_ForwardA),
        .ID_ForwardB      (ID_ForwardB),
        .RF_RsData        (RF_RsData),
        .RF_RtData        (RF_RtData),
        .EXE_Result       (EXE_Result),
        .MEM_Result       (MEM_Result),
        .MEM2_Result      (MEM2_Result),
        .WB_Result        (WB_Result),
        .EXE_ResultValid  (EXE_ResultValid),
        .MEM_ResultValid  (MEM_ResultValid),
        .MEM2_ResultValid (MEM2_ResultValid),
        .ID_Flush         (ID_Flush),
        .EXE_Stall        (EXE_Stall),
        .ID_RsData        (ID_RsData),
        .ID_RtData        (ID_RtData),
        .ID_Stall         (ID_Stall),
        .EXE_Valid        (EXE_Valid),
        .EXE_RsData       (EXE_RsData),
        .EXE_RtData       (EXE_RtData)
    );

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge; inputs are then changed away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ID_Valid = 1'b0; ID_UsesRs = 1'b1; ID_UsesRt = 1'b1;
        ID_ForwardA = 3'b000; ID_ForwardB = 3'b000;
        RF_RsData = '0; RF_RtData = '0;
        EXE_Result = 32'h0000_E0E0; MEM_Result = '0; MEM2_Result = 32'h0000_2222; WB_Result = '0;
        EXE_ResultValid = 1'b0; MEM_ResultValid = 1'b0; MEM2_ResultValid = 1'b0;
        ID_Flush = 1'b0; EXE_Stall = 1'b0;
        tick();
        chk("reset_exe_valid", {31'd0, EXE_Valid}, 32'd0);
        chk("reset_exe_rs", EXE_RsData, 32'd0);
        chk("reset_exe_rt", EXE_RtData, 32'd0);
        chk("reset_id_stall", {31'd0, ID_Stall}, 32'd0);

        // Ready, no hazard
        rst = 1'b0; ID_Valid = 1'b1;
        ID_ForwardA = 3'b000; RF_RsData = 32'h11;
        ID_ForwardB = 3'b100; WB_Result = 32'h22;
        #1;
        chk("ready_stall", {31'd0, ID_Stall}, 32'd0);
        chk("ready_id_rs", ID_RsData, 32'h11);
        chk("ready_id_rt", ID_RtData, 32'h22);
        tick();
        chk("ready_exe_valid", {31'd0, EXE_Valid}, 32'd1);
        chk("ready_exe_rs", EXE_RsData, 32'h11);
        chk("ready_exe_rt", EXE_RtData, 32'h22);

        // Load-use: rs waits on EXE; rt comes from RF and gets captured meanwhile
        ID_ForwardA = 3'b001; EXE_ResultValid = 1'b0;
        ID_ForwardB = 3'b000; RF_RtData = 32'h33;
        #1;
        chk("lu_stall_c0", {31'd0, ID_Stall}, 32'd1);
        tick();
        chk("lu_bubble_c1", {31'd0, EXE_Valid}, 32'd0);
        chk("lu_stall_c1", {31'd0, ID_Stall}, 32'd1);
        tick();
        chk("lu_bubble_c2", {31'd0, EXE_Valid}, 32'd0);
        chk("lu_keep_rs", EXE_RsData, 32'h11);
        ID_ForwardA = 3'b010; MEM_ResultValid = 1'b1; MEM_Result = 32'hDEAD;
        RF_RtData = 32'h44;
        #1;
        chk("lu_release_stall", {31'd0, ID_Stall}, 32'd0);
        chk("lu_id_rs", ID_RsData, 32'hDEAD);
        chk("lu_rt_held", ID_RtData, 32'h33);
        tick();
        chk("lu_exe_valid", {31'd0, EXE_Valid}, 32'd1);
        chk("lu_exe_rs", EXE_RsData, 32'hDEAD);
        chk("lu_exe_rt", EXE_RtData, 32'h33);

        // Capture across EXE stall
        ID_ForwardA = 3'b000; RF_RsData = 32'h10;
        ID_ForwardB = 3'b100; WB_Result = 32'h55;
        EXE_Stall = 1'b1;
        #1;
        chk("cap_stall", {31'd0, ID_Stall}, 32'd1);
        tick();
        chk("cap_exe_frozen_v", {31'd0, EXE_Valid}, 32'd1);
        chk("cap_exe_frozen_rs", EXE_RsData, 32'hDEAD);
        ID_ForwardB = 3'b000; RF_RtData = 32'h99; WB_Result = 32'h5A;
        #1;
        chk("cap_id_rt_held", ID_RtData, 32'h55);
        tick();
        tick();
        EXE_Stall = 1'b0;
        #1;
        chk("cap_release_stall", {31'd0, ID_Stall}, 32'd0);
        tick();
        chk("cap_exe_valid", {31'd0, EXE_Valid}, 32'd1);
        chk("cap_exe_rs", EXE_RsData, 32'h10);
        chk("cap_exe_rt", EXE_RtData, 32'h55);

        // Flush mid-stall
        ID_ForwardA = 3'b001; EXE_ResultValid = 1'b0;
        ID_ForwardB = 3'b100; WB_Result = 32'h66;
        tick();
        chk("fl_bubble", {31'd0, EXE_Valid}, 32'd0);
        ID_Flush = 1'b1;
        #1;
        chk("fl_no_stall", {31'd0, ID_Stall}, 32'd0);
        tick();
        chk("fl_exe_valid", {31'd0, EXE_Valid}, 32'd0);
        ID_Flush = 1'b0;
        ID_ForwardA = 3'b000; RF_RsData = 32'h71;
        ID_ForwardB = 3'b000; RF_RtData = 32'h70;
        #1;
        chk("fl_live_rt", ID_RtData, 32'h70);
        tick();
        chk("fl_new_valid", {31'd0, EXE_Valid}, 32'd1);
        chk("fl_new_rt", EXE_RtData, 32'h70);

        // Flush during EXE_Stall
        RF_RsData = 32'h77; RF_RtData = 32'h77;
        tick();
        chk("fs_setup_rs", EXE_RsData, 32'h77);
        EXE_Stall = 1'b1;
        RF_RsData = 32'h12; ID_ForwardB = 3'b100; WB_Result = 32'h88;
        tick();
        ID_Flush = 1'b1;
        #1;
        chk("fs_no_stall", {31'd0, ID_Stall}, 32'd0);
        tick();
        chk("fs_exe_valid", {31'd0, EXE_Valid}, 32'd1);
        chk("fs_exe_rs", EXE_RsData, 32'h77);
        chk("fs_exe_rt", EXE_RtData, 32'h77);
        ID_Flush = 1'b0; RF_RsData = 32'h13; WB_Result = 32'h89;
        #1;
        chk("fs_live_rs", ID_RsData, 32'h13);
        chk("fs_live_rt", ID_RtData, 32'h89);

        // Reset mid-stall: holds now carry 0x13 / 0x89, EXE valid
        tick();
        rst = 1'b1; RF_RsData = 32'h14;
        #1;
        chk("rs_held_rs", ID_RsData, 32'h13);
        chk("rs_stall_follows", {31'd0, ID_Stall}, 32'd1);
        tick();
        chk("rs_exe_valid", {31'd0, EXE_Valid}, 32'd0);
        chk("rs_exe_rs", EXE_RsData, 32'd0);
        chk("rs_exe_rt", EXE_RtData, 32'd0);
        rst = 1'b0; EXE_Stall = 1'b0; WB_Result = 32'h90;
        #1;
        chk("rs_live_rs", ID_RsData, 32'h14);
        chk("rs_live_rt", ID_RtData, 32'h90);
        chk("rs_no_stall", {31'd0, ID_Stall}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
